scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - 4-channel round-robin scan controller driving a 2-to-4 decoder (optional blanking gap: SCAN_BLANK_EN)
module scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic [1:0]         a,
  output logic               en,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1
`ifdef SCAN_BLANK_EN
    ,
    S_BLANK = 2'd2
`endif
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;

  state_t             state_q, state_d;
  logic [1:0]         a_q, a_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
`ifdef SCAN_BLANK_EN
  logic [1:0]         nxt_q, nxt_d;
  logic               pend_wrap_q, pend_wrap_d;
`endif

  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         first_chan;
  logic [1:0]         next_chan;

  // Lowest enabled channel, used when a scan is launched from IDLE.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) res = 2'(i);
    end
    return res;
  endfunction

  // Next enabled channel strictly after cur in circular order; offset 4 lands
  // back on cur itself, so a lone enabled channel selects itself again.
  function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) res = idx;
    end
    return res;
  endfunction

  // A dwell of zero still holds the channel for one cycle.
  assign dwell_eff  = (dwell == CNT_ZERO) ? CNT_ONE : dwell;
  assign first_chan = lowest_set(mask);
  assign next_chan  = next_set(a_q, mask);

  // Next-state and next-output computation; stop overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    en_d    = en_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef SCAN_BLANK_EN
    nxt_d       = nxt_q;
    pend_wrap_d = pend_wrap_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      a_d     = 2'd0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (mask != 4'd0)) begin
            state_d = S_SCAN;
            a_d     = first_chan;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = dwell_eff;
          end
        end
        S_SCAN: begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (mask == 4'd0) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = CNT_ZERO;
          end else begin
`ifdef SCAN_BLANK_EN
            state_d     = S_BLANK;
            en_d        = 1'b0;
            nxt_d       = next_chan;
            pend_wrap_d = (next_chan <= a_q);
            cnt_d       = CNT_ZERO;
`else
            a_d    = next_chan;
            wrap_d = (next_chan <= a_q);
            cnt_d  = dwell_eff;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        S_BLANK: begin
          state_d     = S_SCAN;
          a_d         = nxt_q;
          en_d        = 1'b1;
          wrap_d      = pend_wrap_q;
          pend_wrap_d = 1'b0;
          cnt_d       = dwell_eff;
        end
`endif
        default: begin
          state_d = S_IDLE;
          a_d     = 2'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
`ifdef SCAN_BLANK_EN
      nxt_q       <= 2'd0;
      pend_wrap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
`ifdef SCAN_BLANK_EN
      nxt_q       <= nxt_d;
      pend_wrap_q <= pend_wrap_d;
`endif
    end
  end

  assign a    = a_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - directed self-checking bench for scan_ctrl
module tb_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic [1:0] a;
  logic       en;
  logic       busy;
  logic       wrap;

  int total;
  int passed;

  scan_ctrl #(.DWELL_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .dwell (dwell),
    .mask  (mask),
    .a     (a),
    .en    (en),
    .busy  (busy),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ea, input logic een,
                         input logic ebusy, input logic ewrap);
    chk({tag, ".a"},    32'(a),    32'(ea));
    chk({tag, ".en"},   32'(en),   32'(een));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
  endtask

  task automatic go_idle();
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    start  = 1'b1;
    stop   = 1'b0;
    dwell  = 8'd3;
    mask   = 4'b1111;
    tick();
    tick();
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;

    // all four channels, dwell 3; start held high while busy is ignored
    start = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      chk_out($sformatf("m1111_c%0d", i), 2'((i / 3) % 4), 1'b1, 1'b1, (i == 12));
      tick();
    end
    go_idle();
    chk_out("after_stop1", 2'd0, 1'b0, 1'b0, 1'b0);

    // channels 1 and 3, dwell 0 behaves as 1
    mask  = 4'b1010;
    dwell = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("m1010_c%0d", i), (i % 2 == 0) ? 2'd1 : 2'd3, 1'b1, 1'b1,
              (i == 2) || (i == 4));
      tick();
    end
    go_idle();

    // stop in second cycle of channel 2, with a simultaneous start
    mask  = 4'b1111;
    dwell = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk_out("stop_pre", 2'd2, 1'b1, 1'b1, 1'b0);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    chk_out("stop_edge", 2'd0, 1'b0, 1'b0, 1'b0);
    stop  = 1'b0;
    start = 1'b0;
    tick();
    chk_out("stop_hold", 2'd0, 1'b0, 1'b0, 1'b0);

    // start with empty mask is ignored
    mask  = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("empty_mask", 2'd0, 1'b0, 1'b0, 1'b0);

    // mask cleared mid-dwell: finish channel 0, then idle without wrap
    mask  = 4'b0001;
    dwell = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("mclr_c0", 2'd0, 1'b1, 1'b1, 1'b0);
    mask  = 4'b0000;
    dwell = 8'd5;
    tick();
    chk_out("mclr_c1", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("mclr_c2", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mclr_end.en", 32'(en), 32'd0);
    chk("mclr_end.busy", 32'(busy), 32'd0);
    chk("mclr_end.wrap", 32'(wrap), 32'd0);
    go_idle();

    // channels 0 and 1, dwell 2
    mask  = 4'b0011;
    dwell = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SCAN_BLANK_EN
    begin
      logic [1:0] ea_t [7];
      logic       een_t[7];
      ea_t  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      een_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
        chk_out($sformatf("blank_c%0d", i), ea_t[i], een_t[i], 1'b1, (i == 6));
        tick();
      end
    end
`else
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("m0011_c%0d", i), 2'((i / 2) % 2), 1'b1, 1'b1, (i == 4));
      tick();
    end
`endif
    go_idle();

    // reset mid-scan, no auto-restart
    mask  = 4'b1111;
    dwell = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk_out("rst_pre", 2'd1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("rst_edge", 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rst_after%0d", i), 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
